// File: rtl/p2s_serializer.sv
// p2s_serializer: word-buffered parallel-to-serial converter for the TX path.
// Define P2S_PARITY_EN to append an even-parity bit after each word.
module p2s_serializer #(
  parameter int inPortWidth  = 4,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int counterWidth = $clog2(inPortWidth)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [inPortWidth-1:0] parallelIn,
  input  logic                   loadValid,
  output logic                   loadReady,
  output logic                   serialOut,
  output logic                   serialValid,
  output logic                   done
);

  localparam int W = inPortWidth;
  localparam logic [counterWidth-1:0] LAST =
    counterWidth'(W - 1);

`ifdef P2S_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  state_t                  state;
  logic [W-1:0]            sr;
  logic [W-1:0]            hb;
  logic                    hb_full;
  logic [counterWidth-1:0] cnt;
`ifdef P2S_PARITY_EN
  logic                    par;
`endif

  logic         accept;
  logic         last;
  logic         next_bit;
  logic [W-1:0] sr_shift;
  logic         boundary;
  logic         sr_load;
  logic [W-1:0] sr_word;
  logic         hb_take;
  logic         hb_drain;

  assign loadReady = ~hb_full;
  assign accept    = loadValid & loadReady;
  assign last      = (cnt == LAST);

  assign next_bit = MSB_FIRST ? sr[W-1] : sr[0];
  assign sr_shift = MSB_FIRST ? {sr[W-2:0], 1'b0}
                              : {1'b0, sr[W-1:1]};

  // Word-boundary decode: where SR may be refilled and where a new word lands
  always_comb begin
    boundary = 1'b0;
    case (state)
      IDLE:    boundary = 1'b1;
`ifdef P2S_PARITY_EN
      SHIFT:   boundary = 1'b0;
      PARITY:  boundary = start;
`else
      SHIFT:   boundary = start & last;
`endif
      default: boundary = 1'b0;
    endcase
    sr_load  = boundary & (hb_full | accept);
    sr_word  = hb_full ? hb : parallelIn;
    hb_drain = boundary & hb_full;
    hb_take  = accept & ~(boundary & ~hb_full);
  end

  // Control FSM with registered serial outputs; SR refill overrides the shift
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      sr          <= '0;
      hb          <= '0;
      hb_full     <= 1'b0;
      cnt         <= '0;
      serialOut   <= 1'b0;
      serialValid <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (hb_take) begin
        hb      <= parallelIn;
        hb_full <= 1'b1;
      end else if (hb_drain) begin
        hb_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          serialValid <= 1'b0;
          done        <= 1'b0;
        end
        SHIFT: begin
          if (start) begin
            serialOut   <= next_bit;
            serialValid <= 1'b1;
            sr          <= sr_shift;
            if (last) begin
              cnt <= '0;
`ifdef P2S_PARITY_EN
              done  <= 1'b0;
              state <= PARITY;
`else
              done  <= 1'b1;
              state <= IDLE;
`endif
            end else begin
              cnt  <= cnt + 1'b1;
              done <= 1'b0;
            end
          end else begin
            serialValid <= 1'b0;
            done        <= 1'b0;
          end
        end
`ifdef P2S_PARITY_EN
        PARITY: begin
          if (start) begin
            serialOut   <= par;
            serialValid <= 1'b1;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            serialValid <= 1'b0;
            done        <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase

      if (sr_load) begin
        sr    <= sr_word;
        cnt   <= '0;
        state <= SHIFT;
      end
    end
  end

`ifdef P2S_PARITY_EN
  // Even parity of the word currently in SR, captured as it is loaded
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par <= 1'b0;
    end else if (sr_load) begin
      par <= ^sr_word;
    end
  end
`endif

endmodule

// File: tb/tb_p2s_serializer.sv
// tb_p2s_serializer: directed vector bench for p2s_serializer.
// Checks an MSB-first and an LSB-first instance side by side.
module tb_p2s_serializer;

  localparam int W = 4;
`ifdef P2S_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [W-1:0] parallelIn;
  logic         loadValid;
  logic rdy_m, so_m, sv_m, dn_m;
  logic rdy_l, so_l, sv_l, dn_l;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  typedef struct {
    logic [W-1:0]  word;
    logic [NB-1:0] exp_m;
    logic [NB-1:0] exp_l;
  } vec_t;

  vec_t vecs[7];
  logic [2*NB-1:0] exp_b2b;
  logic [NB-1:0]   exp_p;

  p2s_serializer #(
    .inPortWidth(W),
    .MSB_FIRST  (1'b1)
  ) dut_m (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .parallelIn (parallelIn),
    .loadValid  (loadValid),
    .loadReady  (rdy_m),
    .serialOut  (so_m),
    .serialValid(sv_m),
    .done       (dn_m)
  );

  p2s_serializer #(
    .inPortWidth(W),
    .MSB_FIRST  (1'b0)
  ) dut_l (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .parallelIn (parallelIn),
    .loadValid  (loadValid),
    .loadReady  (rdy_l),
    .serialOut  (so_l),
    .serialValid(sv_l),
    .done       (dn_l)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
`ifdef P2S_PARITY_EN
    vecs[0] = '{4'b1001, 5'b10010, 5'b10010};
    vecs[1] = '{4'b1101, 5'b11011, 5'b10111};
    vecs[2] = '{4'b1011, 5'b10111, 5'b11011};
    vecs[3] = '{4'b0000, 5'b00000, 5'b00000};
    vecs[4] = '{4'b1000, 5'b10001, 5'b00011};
    vecs[5] = '{4'b1111, 5'b11110, 5'b11110};
    vecs[6] = '{4'b0010, 5'b00101, 5'b01001};
    exp_b2b = 10'b10010_10100;
    exp_p   = 5'b01100;
`else
    vecs[0] = '{4'b1001, 4'b1001, 4'b1001};
    vecs[1] = '{4'b1101, 4'b1101, 4'b1011};
    vecs[2] = '{4'b0110, 4'b0110, 4'b0110};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{4'b1000, 4'b1000, 4'b0001};
    vecs[5] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[6] = '{4'b0010, 4'b0010, 4'b0100};
    exp_b2b = 8'b1001_1010;
    exp_p   = 4'b0110;
`endif

    RST        = 1'b1;
    start      = 1'b1;
    loadValid  = 1'b0;
    parallelIn = '0;
    tick;
    tick;
    chk("rst_so", so_m, 0);
    chk("rst_sv", sv_m, 0);
    chk("rst_done", dn_m, 0);
    chk("rst_ready", rdy_m, 1);
    RST = 1'b0;
    tick;
    chk("post_rst_sv", sv_m, 0);
    chk("post_rst_ready", rdy_m, 1);

    // single-word table
    for (int v = 0; v < 7; v++) begin
      parallelIn = vecs[v].word;
      loadValid  = 1'b1;
      tick;
      loadValid  = 1'b0;
      chk($sformatf("v%0d load_sv", v), sv_m, 0);
      for (int i = 0; i < NB; i++) begin
        tick;
        chk($sformatf("v%0d msb_bit%0d", v, i),
            so_m, vecs[v].exp_m[NB-1-i]);
        chk($sformatf("v%0d lsb_bit%0d", v, i),
            so_l, vecs[v].exp_l[NB-1-i]);
        chk($sformatf("v%0d msb_sv%0d", v, i), sv_m, 1);
        chk($sformatf("v%0d lsb_sv%0d", v, i), sv_l, 1);
        chk($sformatf("v%0d msb_done%0d", v, i),
            dn_m, (i == NB - 1));
        chk($sformatf("v%0d lsb_done%0d", v, i),
            dn_l, (i == NB - 1));
      end
      tick;
      chk($sformatf("v%0d idle_sv", v), sv_m, 0);
      chk($sformatf("v%0d idle_done", v), dn_m, 0);
      chk($sformatf("v%0d idle_ready", v), rdy_m, 1);
    end

    // back-to-back with a third word offered while full
    parallelIn = 4'b1001;
    loadValid  = 1'b1;
    tick;
    parallelIn = 4'b1010;
    for (int i = 0; i < 2 * NB; i++) begin
      tick;
      if (i == 0) parallelIn = 4'b0111;
      if (i == 1) loadValid = 1'b0;
      chk($sformatf("b2b bit%0d", i),
          so_m, exp_b2b[2*NB-1-i]);
      chk($sformatf("b2b sv%0d", i), sv_m, 1);
      chk($sformatf("b2b done%0d", i), dn_m,
          (i == NB - 1) || (i == 2 * NB - 1));
      chk($sformatf("b2b ready%0d", i), rdy_m,
          (i >= NB - 1));
    end
    tick;
    chk("b2b third_not_taken", sv_m, 0);
    chk("b2b end_ready", rdy_m, 1);

    // pause after bit 2 for three cycles
    done_cnt   = 0;
    parallelIn = 4'b0110;
    loadValid  = 1'b1;
    tick;
    loadValid  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      done_cnt += int'(dn_m);
      chk($sformatf("pause bit%0d", i),
          so_m, exp_p[NB-1-i]);
      chk($sformatf("pause sv%0d", i), sv_m, 1);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      done_cnt += int'(dn_m);
      chk($sformatf("paused sv%0d", i), sv_m, 0);
      chk($sformatf("paused hold%0d", i),
          so_m, exp_p[NB-2]);
    end
    start = 1'b1;
    for (int i = 2; i < NB; i++) begin
      tick;
      done_cnt += int'(dn_m);
      chk($sformatf("resume bit%0d", i),
          so_m, exp_p[NB-1-i]);
      chk($sformatf("resume sv%0d", i), sv_m, 1);
      chk($sformatf("resume done%0d", i),
          dn_m, (i == NB - 1));
    end
    tick;
    chk("pause done_count", done_cnt, 1);
    chk("pause end_sv", sv_m, 0);

    // asynchronous reset during bit 2
    parallelIn = 4'b1111;
    loadValid  = 1'b1;
    tick;
    loadValid  = 1'b0;
    tick;
    tick;
    chk("rstmid pre_sv", sv_m, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid so", so_m, 0);
    chk("rstmid sv", sv_m, 0);
    chk("rstmid done", dn_m, 0);
    chk("rstmid ready", rdy_m, 1);
    loadValid = 1'b1;
    tick;
    tick;
    loadValid = 1'b0;
    RST       = 1'b0;
    for (int i = 0; i < NB + 1; i++) begin
      tick;
      chk($sformatf("rstmid after_sv%0d", i), sv_m, 0);
      chk($sformatf("rstmid after_so%0d", i), so_m, 0);
      chk($sformatf("rstmid after_rdy%0d", i), rdy_m, 1);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/p2s_serializer.md
# p2s_serializer

Parallel-to-serial converter for the baseband modulator transmit path; the transmit-side counterpart of the S2P receiver. Accepts `inPortWidth`-bit symbols through a valid/ready handshake, buffers one word ahead, and shifts them out one bit per clock with no gap between consecutive words. Sits between the symbol source and the bit-serial channel/modulator input.

## Interface
Parameters:
- `inPortWidth`, 4, parallel word width; legal range ≥ 2.
- `MSB_FIRST`, 1, 1 = transmit bit `inPortWidth-1` first; 0 = transmit bit 0 first.
- `counterWidth`, `$clog2(inPortWidth)`, bit-counter width; derived, never overridden.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  shift enable; low pauses serialisation.
- `parallelIn`  in  `inPortWidth`  word to transmit.
- `loadValid`  in  1  `parallelIn` valid.
- `loadReady`  out  1  block can accept a word; equals NOT buffer-full.
- `serialOut`  out  1  registered serial bit.
- `serialValid`  out  1  `serialOut` carries a live bit this cycle.
- `done`  out  1  one-cycle pulse on the last bit of each word.

## Operation
- Storage: shift register (SR), one-word holding buffer (HB) with full flag, bit counter `cnt`, and FSM states IDLE and SHIFT, plus PARITY when the macro is defined.
- Accept: a word is taken on any edge with `loadValid && loadReady`, including while `start` = 0. In IDLE with HB empty, the word goes directly to SR. Otherwise it goes to HB.
- IDLE → SHIFT: on the edge where SR is loaded, `cnt` is cleared.
- SHIFT with `start` = 1:
  - Each edge presents the next bit and increments `cnt`.
  - On the last data bit, without the macro:
    - If HB is full, HB moves to SR on the same edge, stays in SHIFT, and HB is cleared.
    - Else, if a word is accepted that edge, it loads SR directly.
    - Else, go to IDLE.
- SHIFT with `start` = 0: `cnt`, SR, `serialOut` and `serialValid` are held, except that `serialValid` is forced to 0. Resume continues from the held bit.
- Bit order follows `MSB_FIRST`. `cnt` wraps to 0 at each word boundary.
- `done` is high exactly during the cycle the final bit of the word is presented.

## Timing
- Reset values: `serialOut` = 0, `serialValid` = 0, `done` = 0, HB empty (`loadReady` = 1), state IDLE. Loads are ignored while `RST` is high.
- Latency: a word accepted at edge k in IDLE has its first bit on `serialOut` from edge k+1, for `inPortWidth` consecutive valid cycles if `start` stays high.
- Back-to-back: with HB full at the last bit, the next word's first bit follows on the very next edge with zero idle cycles.
- Buffer full and SR busy: `loadReady` = 0, and `loadValid` is ignored. HB draining at a word boundary raises `loadReady` on the following cycle.
- Reset mid-word: SR and HB contents are discarded. No `done` pulse is generated.
- `start` falling on the last-bit cycle: that bit's `done` still pulses (it is registered). The next word waits.

## Configuration
- `P2S_PARITY_EN` defined:
  - After the last data bit, enter PARITY for one cycle and output the even-parity bit (XOR of the word) with `serialValid` = 1.
  - `done` pulses with the parity bit, not the last data bit.
  - HB-to-SR handoff happens on the parity edge.
  - Each word occupies `inPortWidth`+1 cycles.
- Not defined: no PARITY state; each word occupies exactly `inPortWidth` cycles.

## Test plan
(`inPortWidth` = 4, `MSB_FIRST` = 1, `start` = 1 unless stated.)
- Single word: load 4'b1001 in IDLE → `serialOut` 1,0,0,1 on the next four cycles. `serialValid` high for 4 cycles. `done` high on the 4th only. Then IDLE with `serialValid` = 0.
- Back-to-back: load 4'b1001, then 4'b1010 while shifting → 8 contiguous valid bits 1,0,0,1,1,0,1,0. `done` on bits 4 and 8. `loadReady` low from the HB load until handoff. A third word offered while full is not taken.
- LSB-first (`MSB_FIRST` = 0): load 4'b1101 → 1,0,1,1.
- Pause: load 4'b0110, drop `start` after bit 2 for 3 cycles → `serialValid` 0 for 3 cycles. Bits 3–4 (1,0) follow on resume. Exactly one `done`.
- Reset mid-word: assert `RST` asynchronously during bit 2 of 4'b1111 → outputs go to 0 immediately. After release, `loadReady` = 1, state is IDLE, and no residual bits appear.
- With `P2S_PARITY_EN`: load 4'b1011 → 1,0,1,1,1, with `done` on the 5th bit. 4'b0000 → 0,0,0,0,0.
